// File: rtl/h264invtransform_if.sv
// h264invtransform_if
//   Coefficient-in / residual-row-out bus of the H.264 inverse 4x4 core transform.
//   Parameters:
//     IW  signed coefficient width
//     OW  signed output residual width
//   Signals:
//     READY   transform can take a coefficient this cycle      (slave -> master)
//     ENABLE  WIN is valid                                     (master -> slave)
//     WIN     signed coefficient, zigzag order, DC first       (master -> slave)
//     VALID   XOUT holds one reconstructed row                 (slave -> master)
//     XOUT    4 residuals, column 0 in the LSBs                (slave -> master)
//     DCSEL   take DCIN instead of WIN for index 0             (master -> slave)
//     DCIN    DC value from the separate Hadamard path         (master -> slave)
//   DCSEL/DCIN exist only when H264_INVTRANSFORM_DCIN_EN is defined.
interface h264invtransform_if #(
    parameter int IW = 16,
    parameter int OW = 9
);
    logic                 READY;
    logic                 ENABLE;
    logic signed [IW-1:0] WIN;
    logic                 VALID;
    logic [4*OW-1:0]      XOUT;
`ifdef H264_INVTRANSFORM_DCIN_EN
    logic                 DCSEL;
    logic signed [IW-1:0] DCIN;

    modport master (input READY, VALID, XOUT, output ENABLE, WIN, DCSEL, DCIN);
    modport slave  (output READY, VALID, XOUT, input ENABLE, WIN, DCSEL, DCIN);
`else
    modport master (input READY, VALID, XOUT, output ENABLE, WIN);
    modport slave  (output READY, VALID, XOUT, input ENABLE, WIN);
`endif
endinterface

// File: rtl/h264invtransform.sv
// h264invtransform
//   Inverse 4x4 integer core transform for the encoder reconstruction loop.
//   Loads 16 dequantised coefficients in zigzag order (one per accepted cycle),
//   runs the horizontal pass over 4 cycles, then the vertical pass over 4 cycles,
//   emitting one rounded and saturated residual row per VALID cycle.
//   No overlap between loading and computing.
//   Ports:
//     CLK    clock
//     RESET  synchronous, active-low reset
//     bus    h264invtransform_if.slave (READY, ENABLE, WIN, VALID, XOUT
//            and, with the option, DCSEL, DCIN)
//   Parameters:
//     IW  coefficient width (row pass uses IW+2, column pass IW+4)
//     OW  output width; outputs saturate to [-2^(OW-1), 2^(OW-1)-1]
//   Option macro: H264_INVTRANSFORM_DCIN_EN
//     When defined, an accept of index 0 with DCSEL=1 stores DCIN in slot (0,0)
//     instead of WIN. When undefined, slot (0,0) always takes WIN.
module h264invtransform #(
    parameter int IW = 16,
    parameter int OW = 9
) (
    input  logic CLK,
    input  logic RESET,
    h264invtransform_if.slave bus
);

    localparam int RW = IW + 2;
    localparam int CW = IW + 4;

    typedef logic signed [CW-1:0] cw_t;
    typedef enum logic [1:0] {S_LOAD, S_ROWS, S_COLS} state_t;

    localparam logic signed [CW:0] SMAX = (CW+1)'((2 ** (OW - 1)) - 1);
    localparam logic signed [CW:0] SMIN = (CW+1)'(-(2 ** (OW - 1)));

    // Shared butterfly; lane 0 (e+h) in the LSBs.
    function automatic logic [4*CW-1:0] bfly(input cw_t d0, input cw_t d1,
                                             input cw_t d2, input cw_t d3);
        cw_t e, f, g, h;
        e = d0 + d2;
        f = d0 - d2;
        g = (d1 >>> 1) - d3;
        h = d1 + (d3 >>> 1);
        return {e - h, f - g, f + g, e + h};
    endfunction

    // (v+32)>>>6 then clamp; one extra bit so the +32 cannot wrap.
    function automatic logic [OW-1:0] sat(input cw_t v);
        logic signed [CW:0] s;
        logic signed [CW:0] t;
        s = $signed({v[CW-1], v}) + (CW+1)'(32);
        t = s >>> 6;
        if (t > SMAX)      return SMAX[OW-1:0];
        else if (t < SMIN) return SMIN[OW-1:0];
        else               return t[OW-1:0];
    endfunction

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [1:0]            ph_q, ph_d;
    logic                  valid_q, valid_d;
    logic [4*OW-1:0]       xout_q, xout_d;

    logic signed [IW-1:0]  c_q [4][4];
    logic signed [RW-1:0]  f_q [4][4];

    logic                  accept;
    logic                  row_we;
    logic [1:0]            zr, zc;
    logic signed [IW-1:0]  coef_in;
    logic [4*CW-1:0]       rowv;
    cw_t                   rowl [4];
    logic [4*CW-1:0]       colv [4];
    logic [4*OW-1:0]       xrow;

    assign bus.READY = (state_q == S_LOAD);
    assign bus.VALID = valid_q;
    assign bus.XOUT  = xout_q;

`ifdef H264_INVTRANSFORM_DCIN_EN
    assign coef_in = ((cnt_q == 4'd0) && bus.DCSEL) ? bus.DCIN : bus.WIN;
`else
    assign coef_in = bus.WIN;
`endif

    // Zigzag index -> (row, col) slot.
    always_comb begin
        zr = 2'd0;
        zc = 2'd0;
        case (cnt_q)
            4'd0:    begin zr = 2'd0; zc = 2'd0; end
            4'd1:    begin zr = 2'd0; zc = 2'd1; end
            4'd2:    begin zr = 2'd1; zc = 2'd0; end
            4'd3:    begin zr = 2'd2; zc = 2'd0; end
            4'd4:    begin zr = 2'd1; zc = 2'd1; end
            4'd5:    begin zr = 2'd0; zc = 2'd2; end
            4'd6:    begin zr = 2'd0; zc = 2'd3; end
            4'd7:    begin zr = 2'd1; zc = 2'd2; end
            4'd8:    begin zr = 2'd2; zc = 2'd1; end
            4'd9:    begin zr = 2'd3; zc = 2'd0; end
            4'd10:   begin zr = 2'd3; zc = 2'd1; end
            4'd11:   begin zr = 2'd2; zc = 2'd2; end
            4'd12:   begin zr = 2'd1; zc = 2'd3; end
            4'd13:   begin zr = 2'd2; zc = 2'd3; end
            4'd14:   begin zr = 2'd3; zc = 2'd2; end
            default: begin zr = 2'd3; zc = 2'd3; end
        endcase
    end

    // Horizontal pass over the row selected by the phase counter.
    always_comb begin
        rowv = bfly(cw_t'(c_q[ph_q][0]), cw_t'(c_q[ph_q][1]),
                    cw_t'(c_q[ph_q][2]), cw_t'(c_q[ph_q][3]));
        for (int unsigned j = 0; j < 4; j++) begin
            rowl[j] = rowv[j*CW +: CW];
        end
    end

    // Vertical pass: every column is transformed, lane ph_q gives output row ph_q.
    always_comb begin
        xrow = '0;
        for (int unsigned j = 0; j < 4; j++) begin
            colv[j] = bfly(cw_t'(f_q[0][j]), cw_t'(f_q[1][j]),
                           cw_t'(f_q[2][j]), cw_t'(f_q[3][j]));
            xrow[j*OW +: OW] = sat(colv[j][32'(ph_q)*CW +: CW]);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ph_d    = ph_q;
        valid_d = 1'b0;
        xout_d  = xout_q;
        accept  = 1'b0;
        row_we  = 1'b0;
        case (state_q)
            S_LOAD: begin
                if (bus.ENABLE) begin
                    accept = 1'b1;
                    cnt_d  = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        cnt_d   = '0;
                        ph_d    = '0;
                        state_d = S_ROWS;
                    end
                end
            end
            S_ROWS: begin
                row_we = 1'b1;
                ph_d   = ph_q + 2'd1;
                if (ph_q == 2'd3) state_d = S_COLS;
            end
            S_COLS: begin
                valid_d = 1'b1;
                xout_d  = xrow;
                ph_d    = ph_q + 2'd1;
                if (ph_q == 2'd3) state_d = S_LOAD;
            end
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q <= S_LOAD;
            cnt_q   <= '0;
            ph_q    <= '0;
            valid_q <= 1'b0;
            xout_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ph_q    <= ph_d;
            valid_q <= valid_d;
            xout_q  <= xout_d;
        end
    end

    // Datapath storage needs no reset: every block rewrites all 16 slots
    // before any of them is read.
    always_ff @(posedge CLK) begin
        if (RESET && accept) c_q[zr][zc] <= coef_in;
        if (RESET && row_we) begin
            for (int unsigned j = 0; j < 4; j++) begin
                f_q[ph_q][j] <= RW'(rowl[j]);
            end
        end
    end

endmodule
